// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: MEM/WB control bit positions, register-file
// geometry and the register-dump FSM state encoding.
package dlx_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  // Bit positions inside the 2-bit MEM/WB write-back control field
  localparam int unsigned WB_CTRL_REGWRITE = 1;
  localparam int unsigned WB_CTRL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StPresent = 2'd2
  } dump_state_e;

endpackage

// File: rtl/wb_dump_fsm.sv
// Register-dump sequencer: walks indices 0..NRegs-1, samples the register array
// through an index/data pair and presents each word on a valid/ready handshake.
module wb_dump_fsm
  import dlx_pkg::*;
#(
  parameter int unsigned NRegs = 32,
  parameter int unsigned DataW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  ready_i,
  output logic [REG_ADDR_W-1:0] rd_idx_o,
  input  logic [DataW-1:0]      rd_data_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] index_o,
  output logic [DataW-1:0]      data_o,
  output logic                  busy_o
);

  localparam logic [REG_ADDR_W-1:0] LastIdx = REG_ADDR_W'(NRegs - 1);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic [REG_ADDR_W-1:0] index_q, index_d;
  logic [DataW-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;

  // Next-state logic; the presented word is only captured in StLoad so it stays
  // frozen across stalls even if the underlying register is rewritten.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_d  = rd_data_i;
        index_d = idx_q;
        valid_d = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and holding registers; reset aborts any dump in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_idx_o = idx_q;
  assign valid_o  = valid_q;
  assign index_o  = index_q;
  assign data_o   = data_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage register file: MEM/WB value mux, 32x32 array with r0 tied to
// zero, two combinational read ports and a handshaked debug dump port.
// Optional macro WB_REGFILE_BYPASS_EN: read ports forward the value being
// written this cycle (write-through) instead of returning the stale array entry.
module wb_register_file #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        WB_control,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [DATA_W-1:0] data_from_ALU,
  input  logic [4:0]        rw,
  input  logic [4:0]        ra,
  input  logic [4:0]        rb,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);

  import dlx_pkg::*;

  logic [DATA_W-1:0]     regs_q [NREGS];
  logic [DATA_W-1:0]     wb_value;
  logic                  reg_write;
  logic                  commit;
  logic [REG_ADDR_W-1:0] dump_rd_idx;
  logic [DATA_W-1:0]     dump_rd_data;

  assign wb_value  = WB_control[WB_CTRL_MEMTOREG] ? data_from_mem : data_from_ALU;
  assign reg_write = WB_control[WB_CTRL_REGWRITE];
  assign commit    = reg_write && (rw != '0) && (32'(rw) < NREGS);

  // Register array; writes to r0 never commit so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[rw] <= wb_value;
    end
  end

  // Combinational read ports
  always_comb begin
    bus_a = (ra == '0) ? '0 : regs_q[ra];
    bus_b = (rb == '0) ? '0 : regs_q[rb];
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (ra == rw)) bus_a = wb_value;
    if (commit && (rb == rw)) bus_b = wb_value;
`endif
  end

  // Dump port sees the array before this edge's write
  assign dump_rd_data = regs_q[dump_rd_idx];

  wb_dump_fsm #(
    .NRegs (NREGS),
    .DataW (DATA_W)
  ) u_dump_fsm (
    .clk_i     (clk),
    .rst_ni    (reset),
    .start_i   (dump_start),
    .ready_i   (dump_ready),
    .rd_idx_o  (dump_rd_idx),
    .rd_data_i (dump_rd_data),
    .valid_o   (dump_valid),
    .index_o   (dump_index),
    .data_o    (dump_data),
    .busy_o    (dump_busy)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed vector table, randomized
// traffic against an array model, dump with backpressure and dump abort.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WB_control;
  logic [31:0] data_from_mem;
  logic [31:0] data_from_ALU;
  logic [4:0]  rw, ra, rb;
  logic [31:0] bus_a, bus_b;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        dump_busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] model [32];

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [7];

  wb_register_file dut (
    .clk           (clk),
    .reset         (reset),
    .WB_control    (WB_control),
    .data_from_mem (data_from_mem),
    .data_from_ALU (data_from_ALU),
    .rw            (rw),
    .ra            (ra),
    .rb            (rb),
    .bus_a         (bus_a),
    .bus_b         (bus_b),
    .dump_start    (dump_start),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_index    (dump_index),
    .dump_data     (dump_data),
    .dump_busy     (dump_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] cur_wb();
    return WB_control[0] ? data_from_mem : data_from_ALU;
  endfunction

  // Reference read: architectural contents, plus write-through when enabled
  function automatic logic [31:0] exp_read(input logic [4:0] a);
`ifdef WB_REGFILE_BYPASS_EN
    if (WB_control[1] && rw != 5'd0 && a == rw) return cur_wb();
`endif
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance one clock; model commits what the DUT should commit at this edge
  task automatic commit_tick();
    if (WB_control[1] && rw != 5'd0) model[rw] = cur_wb();
    @(posedge clk);
    #1;
  endtask

  // Runs a full dump already started; expects word k = k*0x11 or zero
  task automatic run_dump(input bit rand_ready, input bit pattern);
    int k = 0;
    int cycles = 0;
    bit injected = 1'b0;
    logic [31:0] exp_d;
    while (k < 32 && cycles < 2000) begin
      WB_control = 2'b00;
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_start = (k == 5 && !injected);
      if (k == 5) injected = 1'b1;
      if (dump_valid) begin
        exp_d = pattern ? 32'(k * 32'h11) : 32'h0;
        check("dump_index", {27'b0, dump_index}, 32'(k));
        check("dump_data", dump_data, exp_d);
        if (dump_ready) begin
          k++;
        end else if (dump_index != 5'd0) begin
          // Rewrite the presented register while stalled; held word must not move
          WB_control    = 2'b10;
          rw            = dump_index;
          data_from_ALU = 32'hBAD0_0000 | 32'(cycles);
        end
      end
      commit_tick();
      cycles++;
    end
    dump_start = 1'b0;
    WB_control = 2'b00;
    check("dump_words", 32'(k), 32'd32);
    check("dump_min_cycles", 32'(cycles >= 64), 32'd1);
    check("dump_busy_end", {31'b0, dump_busy}, 32'd0);
    check("dump_valid_end", {31'b0, dump_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'h0,         32'h1234_5678, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0};
    vecs[1] = '{2'b11, 32'hDEAD_BEEF, 32'h0,         5'd5, 5'd5, 5'd5,
                32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{2'b01, 32'h1111_1111, 32'h2222_2222, 5'd5, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{2'b10, 32'h0,         32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF};
    vecs[4] = '{2'b10, 32'h0,         32'hA5A5_A5A5, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0};
    vecs[5] = '{2'b00, 32'h0,         32'h0,         5'd7, 5'd7, 5'd5,
                32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[6] = '{2'b00, 32'h0,         32'h0,         5'd0, 5'd0, 5'd7, 32'h0, 32'hA5A5_A5A5};

    reset = 1'b0;
    WB_control = 2'b00;
    data_from_mem = '0;
    data_from_ALU = '0;
    rw = '0; ra = 5'd3; rb = 5'd31;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_valid", {31'b0, dump_valid}, 32'd0);
    check("rst_busy", {31'b0, dump_busy}, 32'd0);
    check("rst_index", {27'b0, dump_index}, 32'd0);
    check("rst_data", dump_data, 32'h0);
    check("rst_bus_a", bus_a, 32'h0);
    check("rst_bus_b", bus_b, 32'h0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      logic [31:0] ea, eb, wb;
      WB_control    = vecs[i].ctrl;
      data_from_mem = vecs[i].mem;
      data_from_ALU = vecs[i].alu;
      rw = vecs[i].rw; ra = vecs[i].ra; rb = vecs[i].rb;
      ea = vecs[i].ea;
      eb = vecs[i].eb;
      wb = vecs[i].ctrl[0] ? vecs[i].mem : vecs[i].alu;
`ifdef WB_REGFILE_BYPASS_EN
      if (vecs[i].ctrl[1] && vecs[i].rw != 5'd0 && vecs[i].ra == vecs[i].rw) ea = wb;
      if (vecs[i].ctrl[1] && vecs[i].rw != 5'd0 && vecs[i].rb == vecs[i].rw) eb = wb;
`else
      if (wb == 32'hFFFF_FFFF) ea = vecs[i].ea;
`endif
      #1;
      check($sformatf("vec%0d_bus_a", i), bus_a, ea);
      check($sformatf("vec%0d_bus_b", i), bus_b, eb);
      commit_tick();
    end

    // Randomized traffic against the array model
    for (int i = 0; i < 300; i++) begin
      WB_control    = 2'($urandom);
      data_from_mem = $urandom;
      data_from_ALU = $urandom;
      rw = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      #1;
      check("rand_bus_a", bus_a, exp_read(ra));
      check("rand_bus_b", bus_b, exp_read(rb));
      commit_tick();
    end

    // Dump with random backpressure, after loading regs[i] = i*0x11
    for (int i = 1; i < 32; i++) begin
      WB_control    = 2'b10;
      rw            = 5'(i);
      data_from_ALU = 32'(i * 32'h11);
      commit_tick();
    end
    WB_control = 2'b00;
    dump_start = 1'b1;
    commit_tick();
    dump_start = 1'b0;
    check("dump_busy_start", {31'b0, dump_busy}, 32'd1);
    run_dump(1'b1, 1'b1);

    // Dump abort: reset at index 10
    dump_ready = 1'b1;
    dump_start = 1'b1;
    commit_tick();
    dump_start = 1'b0;
    begin
      int guard = 0;
      while (!(dump_valid && dump_index == 5'd10) && guard < 200) begin
        commit_tick();
        guard++;
      end
      check("abort_reach_10", 32'(guard < 200), 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_valid", {31'b0, dump_valid}, 32'd0);
    check("abort_busy", {31'b0, dump_busy}, 32'd0);
    check("abort_index", {27'b0, dump_index}, 32'd0);
    check("abort_data", dump_data, 32'h0);
    clear_model();
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      rb = 5'(31 - i);
      #1;
      check("abort_bus_a", bus_a, 32'h0);
      check("abort_bus_b", bus_b, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    dump_start = 1'b1;
    commit_tick();
    dump_start = 1'b0;
    run_dump(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
